// File: rtl/bcluster_if.sv
// Operand/result bundle between the tile scheduler (master) and one bcluster (slave).
// Widths follow the cluster geometry; lane l, element k sits at index (l*K+k).
interface bcluster_if #(
  parameter int NUM_TG = 2,
  parameter int LANES  = 4,
  parameter int K      = 4,
  parameter int AW     = 8,
  parameter int WW     = 8,
  parameter int PW     = 16,
  parameter int SHW    = 3
);
  localparam int L = NUM_TG * LANES;

  logic                  w_valid;
  logic                  w_ready;
  logic [L*K*WW-1:0]     w_data;
  logic [L*K-1:0]        w_sign;
  logic [L*SHW-1:0]      w_shift;

  logic                  in_valid;
  logic                  in_ready;
  logic [K*AW-1:0]       in_act;
  logic [L*PW-1:0]       in_psum;
  logic                  in_mode;
  logic                  in_last;

  logic                  out_valid;
  logic                  out_ready;
  logic [L*PW-1:0]       out_result;
  logic                  busy;

  modport master (
    output w_valid, w_data, w_sign, w_shift,
    output in_valid, in_act, in_psum, in_mode, in_last,
    output out_ready,
    input  w_ready, in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  w_valid, w_data, w_sign, w_shift,
    input  in_valid, in_act, in_psum, in_mode, in_last,
    input  out_ready,
    output w_ready, in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/bcluster.sv
// Broadcast dot-product cluster: L lanes share one activation vector, double-buffered
// weights swap between tiles, two-stage valid/ready pipeline with optional tile accumulation.
module bcluster #(
  parameter int NUM_TG = 2,
  parameter int LANES  = 4,
  parameter int K      = 4,
  parameter int AW     = 8,
  parameter int WW     = 8,
  parameter int PW     = 16,
  parameter int SHW    = 3
) (
  input logic       clk,
  input logic       rstn,
  bcluster_if.slave bus
);
  localparam int L   = NUM_TG * LANES;
  localparam int PRW = AW + WW + 1;
  localparam int FW  = PRW + $clog2(K) + (1 << SHW) - 1;
  localparam int ACW = ((FW > PW) ? FW : PW) + 2;

  localparam logic signed [ACW-1:0] SAT_MAX = (ACW'(1) <<< (PW - 1)) - ACW'(1);
  localparam logic signed [ACW-1:0] SAT_MIN = ~SAT_MAX;

  // Signed activation times unsigned magnitude; both are widened to PRW so the product is exact.
  function automatic logic signed [FW-1:0] lane_sum(
    input logic [K*AW-1:0] act,
    input logic [K*WW-1:0] w,
    input logic [K-1:0]    sg,
    input logic [SHW-1:0]  sh
  );
    logic signed [FW-1:0]  acc;
    logic signed [PRW-1:0] a_x, w_x, p;
    acc = '0;
    for (int k = 0; k < K; k++) begin
      a_x = PRW'($signed(act[k*AW +: AW]));
      w_x = PRW'({1'b0, w[k*WW +: WW]});
      p   = a_x * w_x;
      if (sg[k]) p = -p;
      acc = acc + FW'(p);
    end
    return acc <<< sh;
  endfunction

  function automatic logic [PW-1:0] sat(input logic signed [ACW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[PW-1:0];
    if (v < SAT_MIN) return SAT_MIN[PW-1:0];
    return v[PW-1:0];
  endfunction

  logic [L*K*WW-1:0]    act_w_q, shd_w_q;
  logic [L*K-1:0]       act_sign_q, shd_sign_q;
  logic [L*SHW-1:0]     act_shift_q, shd_shift_q;
  logic                 shadow_full_q, tile_open_q;

  logic                 s1_valid_q, s1_mode_q, s1_first_q, s1_last_q;
  logic signed [FW-1:0] s1_s_q [L];
  logic [L*PW-1:0]      s1_psum_q;

  logic signed [ACW-1:0] acc_q [L];
  logic                  out_valid_q;
  logic [L*PW-1:0]       out_result_q;

  logic advance, swap_now, load_fire, in_ready, accept, eff_mode;
  logic signed [FW-1:0]  s_comb [L];
  logic signed [ACW-1:0] acc_d  [L];
  logic [L*PW-1:0]       result_d;

  assign load_fire = bus.w_valid && !shadow_full_q;
  assign swap_now  = shadow_full_q && !tile_open_q;
  assign advance   = !out_valid_q || bus.out_ready;
  assign in_ready  = advance && !swap_now;
  assign accept    = bus.in_valid && in_ready;
  // Mode is latched by the tile: once open, every beat accumulates regardless of in_mode.
  assign eff_mode  = tile_open_q || bus.in_mode;

  always_comb begin
    for (int l = 0; l < L; l++) begin
      s_comb[l] = lane_sum(bus.in_act, act_w_q[l*K*WW +: K*WW],
                           act_sign_q[l*K +: K], act_shift_q[l*SHW +: SHW]);
    end
  end

  // NOTE: every variable is assigned on every path through always_comb, so no latch can form.
  always_comb begin
    result_d = '0;
    for (int l = 0; l < L; l++) begin
      acc_d[l] = ((s1_mode_q && !s1_first_q) ? acc_q[l]
                                             : ACW'($signed(s1_psum_q[l*PW +: PW])))
                 + ACW'(s1_s_q[l]);
      result_d[l*PW +: PW] = sat(acc_d[l]);
    end
  end

  // NOTE: the weight banks are reset too, so a post-reset beat never sees stale weights.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_w_q       <= '0;
      act_sign_q    <= '0;
      act_shift_q   <= '0;
      shd_w_q       <= '0;
      shd_sign_q    <= '0;
      shd_shift_q   <= '0;
      shadow_full_q <= 1'b0;
      tile_open_q   <= 1'b0;
    end else begin
      // Load needs an empty shadow and swap needs a full one, so they are exclusive.
      if (load_fire) begin
        shd_w_q       <= bus.w_data;
        shd_sign_q    <= bus.w_sign;
        shd_shift_q   <= bus.w_shift;
        shadow_full_q <= 1'b1;
      end else if (swap_now) begin
        act_w_q       <= shd_w_q;
        act_sign_q    <= shd_sign_q;
        act_shift_q   <= shd_shift_q;
        shadow_full_q <= 1'b0;
      end
      if (accept && eff_mode) tile_open_q <= !bus.in_last;
    end
  end

  // NOTE: non-blocking assignments keep every register update in step with the clock edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_s_q       <= '{default: '0};
      s1_psum_q    <= '0;
      acc_q        <= '{default: '0};
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else if (advance) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_s_q     <= s_comb;
        s1_psum_q  <= bus.in_psum;
        s1_mode_q  <= eff_mode;
        s1_first_q <= !tile_open_q;
        s1_last_q  <= bus.in_last;
      end
      out_valid_q <= s1_valid_q && (!s1_mode_q || s1_last_q);
      if (s1_valid_q) begin
        if (s1_mode_q) acc_q <= acc_d;
        if (!s1_mode_q || s1_last_q) out_result_q <= result_d;
      end
    end
  end

  assign bus.w_ready    = !shadow_full_q;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.busy       = s1_valid_q || out_valid_q || tile_open_q;
endmodule

// File: tb/tb_bcluster.sv
// Directed bench for bcluster: reset, arithmetic, saturation, accumulation,
// backpressure, deferred weight swap and reset mid-tile.
module tb_bcluster;
  localparam int NUM_TG = 2;
  localparam int LANES  = 4;
  localparam int K      = 4;
  localparam int AW     = 8;
  localparam int WW     = 8;
  localparam int PW     = 16;
  localparam int SHW    = 3;
  localparam int L      = NUM_TG * LANES;

  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  int   n_mark;

  bcluster_if #(.NUM_TG(NUM_TG), .LANES(LANES), .K(K), .AW(AW), .WW(WW), .PW(PW), .SHW(SHW)) bus ();

  bcluster #(.NUM_TG(NUM_TG), .LANES(LANES), .K(K), .AW(AW), .WW(WW), .PW(PW), .SHW(SHW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn && bus.out_valid && bus.out_ready) n_out <= n_out + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L*PW-1:0] pv(input logic [PW-1:0] x);
    return {L{x}};
  endfunction

  function automatic logic signed [PW-1:0] lane(input int i);
    return bus.out_result[i*PW +: PW];
  endfunction

  // Present one beat and hold it until the cycle in which it is accepted.
  task automatic beat(input logic [AW-1:0] act, input logic [L*PW-1:0] psum,
                      input logic mode, input logic last);
    int n;
    n = 0;
    bus.in_act   = {K{act}};
    bus.in_psum  = psum;
    bus.in_mode  = mode;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    check("beat_in_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Mode-0 beat: out_valid two cycles after the handshake cycle, checked on first and last lane.
  task automatic run0(input string tag, input logic [AW-1:0] act,
                      input logic [PW-1:0] psum, input int exp);
    beat(act, pv(psum), 1'b0, 1'b0);
    check({tag, "_early"}, bus.out_valid, 1'b0);
    step();
    check({tag, "_valid"}, bus.out_valid, 1'b1);
    check({tag, "_lane0"}, lane(0), exp);
    check({tag, "_laneN"}, lane(L-1), exp);
    step();
  endtask

  // Load with the tile closed: the swap follows immediately and stalls input for one cycle.
  task automatic load_weights(input logic [WW-1:0] w, input logic sg, input logic [SHW-1:0] sh);
    bus.w_data  = {L*K{w}};
    bus.w_sign  = {L*K{sg}};
    bus.w_shift = {L{sh}};
    bus.w_valid = 1'b1;
    check("load_w_ready", bus.w_ready, 1'b1);
    step();
    bus.w_valid = 1'b0;
    check("swap_in_ready_low", bus.in_ready, 1'b0);
    step();
    check("swap_in_ready_back", bus.in_ready, 1'b1);
    check("swap_w_ready_back", bus.w_ready, 1'b1);
  endtask

  initial begin
    rstn          = 1'b0;
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;
    bus.w_sign    = '0;
    bus.w_shift   = '0;
    bus.in_valid  = 1'b0;
    bus.in_act    = '0;
    bus.in_psum   = '0;
    bus.in_mode   = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values.
    step();
    step();
    rstn = 1'b1;
    step();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_w_ready", bus.w_ready, 1'b1);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_result", lane(0), 0);

    // Zero weights pass psum through; only lane 0 carries 100.
    beat(8'd5, {{(L-1)*PW{1'b0}}, 16'd100}, 1'b0, 1'b0);
    check("zw_early", bus.out_valid, 1'b0);
    step();
    check("zw_valid", bus.out_valid, 1'b1);
    check("zw_lane0", lane(0), 100);
    check("zw_lane1", lane(1), 0);
    step();
    check("zw_drain", bus.out_valid, 1'b0);

    // Arithmetic: 4 * (3*2) = 24.
    load_weights(8'd2, 1'b0, 3'd0);
    run0("plain", 8'd3, 16'd10, 34);
    run0("sat_pos", 8'd3, 16'h7fff, 32767);
    load_weights(8'd2, 1'b0, 3'd1);
    run0("shift1", 8'd3, 16'd10, 58);
    load_weights(8'd2, 1'b1, 3'd0);
    run0("neg", 8'd3, 16'd10, -14);
    run0("sat_neg", 8'd3, 16'h8000, -32768);
    load_weights(8'd2, 1'b0, 3'd0);

    // Accumulate: 5 + 3*24 = 77, one output, psum of later beats ignored.
    n_mark = n_out;
    beat(8'd3, pv(16'd5), 1'b1, 1'b0);
    check("acc_b1_nv", bus.out_valid, 1'b0);
    check("acc_busy", bus.busy, 1'b1);
    beat(8'd3, pv(16'd999), 1'b1, 1'b0);
    check("acc_b2_nv", bus.out_valid, 1'b0);
    beat(8'd3, pv(16'd999), 1'b0, 1'b1);
    check("acc_b3_nv", bus.out_valid, 1'b0);
    step();
    check("acc_valid", bus.out_valid, 1'b1);
    check("acc_lane0", lane(0), 77);
    check("acc_laneN", lane(L-1), 77);
    step();
    step();
    check("acc_once", n_out - n_mark, 1);

    // Backpressure: two beats, first result held for 4 cycles.
    bus.out_ready = 1'b0;
    n_mark = n_out;
    beat(8'd3, pv(16'd10), 1'b0, 1'b0);
    beat(8'd3, pv(16'd20), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", bus.in_ready, 1'b0);
      check("bp_valid", bus.out_valid, 1'b1);
      check("bp_hold", lane(0), 34);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_second_valid", bus.out_valid, 1'b1);
    check("bp_second", lane(0), 44);
    step();
    check("bp_drain", bus.out_valid, 1'b0);
    check("bp_count", n_out - n_mark, 2);

    // Deferred swap: shadow loaded mid-tile, swap only after in_last.
    beat(8'd3, pv(16'd5), 1'b1, 1'b0);
    bus.w_data  = {L*K{8'd1}};
    bus.w_sign  = '0;
    bus.w_shift = '0;
    bus.w_valid = 1'b1;
    step();
    bus.w_valid = 1'b0;
    check("def_w_ready", bus.w_ready, 1'b0);
    check("def_no_swap", bus.in_ready, 1'b1);
    beat(8'd3, pv(16'd0), 1'b1, 1'b0);
    check("def_still_full", bus.w_ready, 1'b0);
    beat(8'd3, pv(16'd0), 1'b1, 1'b1);
    check("def_swap_stall", bus.in_ready, 1'b0);
    step();
    check("def_in_ready", bus.in_ready, 1'b1);
    check("def_w_ready_back", bus.w_ready, 1'b1);
    check("def_valid", bus.out_valid, 1'b1);
    check("def_acc", lane(0), 77);
    step();
    run0("new_w", 8'd3, 16'd10, 22);

    // Reset mid-tile with a pending shadow.
    n_mark = n_out;
    beat(8'd3, pv(16'd5), 1'b1, 1'b0);
    beat(8'd3, pv(16'd0), 1'b1, 1'b0);
    bus.w_data  = {L*K{8'd3}};
    bus.w_valid = 1'b1;
    step();
    bus.w_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("mr_out_valid", bus.out_valid, 1'b0);
    check("mr_result", lane(0), 0);
    check("mr_busy", bus.busy, 1'b0);
    check("mr_w_ready", bus.w_ready, 1'b1);
    check("mr_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("mr_no_late", bus.out_valid, 1'b0);
      check("mr_no_swap", bus.in_ready, 1'b1);
      step();
    end
    check("mr_count", n_out - n_mark, 0);
    run0("mr_zero_w", 8'd3, 16'd7, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcluster.md
# bcluster

Parametrised successor to the two-thread-group octet tile. It holds NUM_TG×LANES output lanes that share one broadcast activation vector, and each lane computes a signed, shifted K-element dot product plus a partial sum. It adds three things the octet lacks: double-buffered weights with a safe shadow→active swap, valid/ready streaming with backpressure, and an optional internal accumulation mode across a multi-beat tile. It sits between the tile-level operand scheduler and the psum writeback path.

## Interface
- NUM_TG, 2, thread groups; total lanes L = NUM_TG×LANES
- LANES, 4, lanes per thread group
- K, 4, activations per dot product
- AW, 8, activation width (signed)
- WW, 8, weight magnitude width (unsigned)
- PW, 16, psum/result width (signed)
- SHW, 3, per-lane shift width
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- w_valid  in  1  shadow weight load request
- w_ready  out  1  shadow bank empty
- w_data  in  L×K×WW  magnitudes; lane l, element k at index (l×K+k)×WW
- w_sign  in  L×K  1 = negate product
- w_shift  in  L×SHW  per-lane left shift
- in_valid / in_ready  in / out  1  input beat handshake
- in_act  in  K×AW  activation vector, broadcast to all lanes
- in_psum  in  L×PW  external partial sums (seed in accumulate mode)
- in_mode  in  1  0 = per-beat, 1 = accumulate; sampled on the first beat of a tile
- in_last  in  1  last beat of the tile (mode 1 only)
- out_valid / out_ready  out / in  1  result handshake
- out_result  out  L×PW  saturated results
- busy  out  1  stage-1 valid, out_valid, or tile open

## Operation
- Per lane: p_k = a_k × w_k (signed × unsigned), negated if sign_k. S = (Σ p_k) << shift, computed at full precision of AW+WW+1+clog2(K)+2^SHW−1 bits.
- Mode 0: result = sat(in_psum + S). Every accepted beat produces one output.
- Mode 1: the first beat of a tile sets acc = in_psum + S. Later beats set acc = acc + S, and in_psum is ignored on those beats. Only the in_last beat produces an output, sat(acc). acc is held at full precision and saturated once at output.
- sat clamps to [−2^(PW−1), 2^(PW−1)−1].
- Tile open: set by a mode-1 beat with in_last=0. Cleared by the accepted in_last beat. It is never set in mode 0.
- Weights:
  - w_ready = !shadow_full. A load fires on w_valid && w_ready, copies all weight inputs to the shadow bank and sets shadow_full.
  - The swap is automatic. It happens in the first cycle with shadow_full && !tile_open: active ← shadow and shadow_full clears. in_ready = 0 in that cycle.
  - A load and a swap never occur in the same cycle.
- Stage 1 uses the active weights at beat acceptance, so a swap never corrupts an in-flight beat.
- Reset: all registers clear, including both weight banks, acc, tile_open and shadow_full. Outputs: out_valid=0, out_result=0, busy=0, w_ready=1, in_ready=1.
- Reset mid-tile discards the partial accumulation and any pending shadow.

## Timing
- Two-stage pipeline: stage 1 registers S per lane; stage 2 registers out_result/out_valid.
- A mode-0 beat accepted at edge N gives out_valid at edge N+2, provided no stall occurs.
- Pipeline advance = !out_valid || out_ready. in_ready = advance && !swap_now (combinational).
- While out_valid && !out_ready: both stages hold, and out_result stays stable.
- Mode 1: non-last beats fill the pipeline but do not raise out_valid. Back-to-back beats issue one per cycle; stage 2 updates acc every cycle, so no bubble is required.
- A swap pending during an open tile is deferred. The swap occurs in the cycle after the in_last beat is accepted (while the tile is closed and shadow_full is set). That cycle drops in_ready to 0 for exactly one cycle, and the next accepted beat uses the new weights.

## Test plan
- Reset: after rstn release, out_valid=0, w_ready=1, in_ready=1. A mode-0 beat with psum lane0=100 and zero weights -> out_result lane0=100 at N+2.
- Arithmetic: load w=2, sign=0, shift=0 and wait for the swap; act all 3, psum 10 -> 34 on every lane. With shift=1 -> 58. With sign=1 and shift=0 -> −14.
- Saturation: psum 32767, S=+24 -> 32767. Psum −32768, S=−24 -> −32768.
- Accumulate: mode 1, 3 beats each S=24, seed psum 5, in_last on beat 3 -> exactly one output of 77; no out_valid after beats 1–2.
- Backpressure: hold out_ready=0 for 4 cycles with a pending result -> in_ready=0, out_result stable, no beat lost or duplicated.
- Deferred swap and reset: load the shadow mid-tile -> w_ready=0; swap occurs only after in_last; post-tile beats use new weights. Assert rstn mid-tile -> all outputs at reset values, with no late output.
